// File: rtl/guess_entry.sv
// guess_entry -- keypad guess collector feeding a code matcher.
//
// Collects up to four decimal digits from a keypad strobe, then on enter
// runs a one-cycle check. An accepted guess produces a one-cycle match
// pulse. A rejected guess produces a one-cycle err pulse and wipes the
// digits. Keys that arrive while a check is in flight are dropped.
//
// Optional feature macro: GUESS_DUP_CHECK_EN
//    defined   : a guess containing any repeated digit is rejected
//    undefined : every complete guess is accepted and err stays low
//
// Ports
//    clk        in   1  rising-edge clock
//    rst        in   1  asynchronous active-high reset
//    key_valid  in   1  one-cycle key strobe
//    key_code   in   4  0-9 digit, C clear, E enter, A/B/D/F ignored
//    a1..a4     out  4  stored digits, a1 is the first entered
//    match      out  1  one-cycle pulse, guess accepted
//    cnt        out  3  number of digits held (0-4)
//    err        out  1  one-cycle pulse, guess rejected
module guess_entry (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic [3:0] a1,
   output logic [3:0] a2,
   output logic [3:0] a3,
   output logic [3:0] a4,
   output logic       match,
   output logic [2:0] cnt,
   output logic       err
);

   typedef enum logic [1:0] {
      ENTRY = 2'd0,
      CHECK = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] KEY_CLEAR = 4'hC;
   localparam logic [3:0] KEY_ENTER = 4'hE;

   state_t     state_q, state_d;
   logic [3:0] a1_q, a1_d;
   logic [3:0] a2_q, a2_d;
   logic [3:0] a3_q, a3_d;
   logic [3:0] a4_q, a4_d;
   logic [2:0] cnt_q, cnt_d;
   logic       match_q, match_d;
   logic       err_q, err_d;
   // A rejection is decided at the end of CHECK but err must appear one
   // cycle later, aligned with where match would have appeared.
   logic       err_pend_q, err_pend_d;

   logic is_digit;
   logic is_clear;
   logic is_enter;
   logic guess_invalid;

   assign is_digit = (key_code <= 4'd9);
   assign is_clear = (key_code == KEY_CLEAR);
   assign is_enter = (key_code == KEY_ENTER);

`ifdef GUESS_DUP_CHECK_EN
   // Any repeated digit among the four held digits rejects the guess.
   assign guess_invalid = (a1_q == a2_q) || (a1_q == a3_q) || (a1_q == a4_q) ||
                          (a2_q == a3_q) || (a2_q == a4_q) || (a3_q == a4_q);
`else
   assign guess_invalid = 1'b0;
`endif

   // State and data registers; reset clears everything including any
   // pulse that was about to be issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ENTRY;
         a1_q       <= 4'd0;
         a2_q       <= 4'd0;
         a3_q       <= 4'd0;
         a4_q       <= 4'd0;
         cnt_q      <= 3'd0;
         match_q    <= 1'b0;
         err_q      <= 1'b0;
         err_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a1_q       <= a1_d;
         a2_q       <= a2_d;
         a3_q       <= a3_d;
         a4_q       <= a4_d;
         cnt_q      <= cnt_d;
         match_q    <= match_d;
         err_q      <= err_d;
         err_pend_q <= err_pend_d;
      end
   end

   // Next-state and datapath logic. Keys are only looked at in ENTRY, so
   // anything pressed during CHECK or DONE (clear included) is dropped.
   always_comb begin
      state_d    = state_q;
      a1_d       = a1_q;
      a2_d       = a2_q;
      a3_d       = a3_q;
      a4_d       = a4_q;
      cnt_d      = cnt_q;
      match_d    = 1'b0;
      err_d      = err_pend_q;
      err_pend_d = 1'b0;

      case (state_q)
         ENTRY: begin
            if (key_valid) begin
               if (is_digit) begin
                  // A fifth digit is silently dropped.
                  if (cnt_q < 3'd4) begin
                     case (cnt_q)
                        3'd0:    a1_d = key_code;
                        3'd1:    a2_d = key_code;
                        3'd2:    a3_d = key_code;
                        default: a4_d = key_code;
                     endcase
                     cnt_d = cnt_q + 3'd1;
                  end
               end else if (is_clear) begin
                  cnt_d = 3'd0;
                  a1_d  = 4'd0;
                  a2_d  = 4'd0;
                  a3_d  = 4'd0;
                  a4_d  = 4'd0;
               end else if (is_enter && (cnt_q == 3'd4)) begin
                  state_d = CHECK;
               end
            end
         end

         CHECK: begin
            if (guess_invalid) begin
               state_d    = ENTRY;
               err_pend_d = 1'b1;
               cnt_d      = 3'd0;
               a1_d       = 4'd0;
               a2_d       = 4'd0;
               a3_d       = 4'd0;
               a4_d       = 4'd0;
            end else begin
               state_d = DONE;
            end
         end

         DONE: begin
            // Digits stay visible to the matcher while match is high; only
            // the count is reset so the next digit lands in a1.
            state_d = ENTRY;
            cnt_d   = 3'd0;
            match_d = 1'b1;
         end

         default: begin
            state_d = ENTRY;
         end
      endcase
   end

   assign a1    = a1_q;
   assign a2    = a2_q;
   assign a3    = a3_q;
   assign a4    = a4_q;
   assign cnt   = cnt_q;
   assign match = match_q;
   assign err   = err_q;

endmodule

// File: tb/tb_guess_entry.sv
// tb_guess_entry -- self-checking bench for guess_entry.
//
// The reference model tracks the held digits as a small array and treats an
// accepted enter as a set of future events (when keys are dropped, when the
// count resets, when a pulse is due) scheduled by absolute edge number.
// Build with +define+GUESS_DUP_CHECK_EN to exercise the rejection path.
module tb_guess_entry;

   logic       clk;
   logic       rst;
   logic       key_valid;
   logic [3:0] key_code;
   logic [3:0] a1, a2, a3, a4;
   logic       match;
   logic [2:0] cnt;
   logic       err;

   int checks = 0;
   int errors = 0;

   guess_entry dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .a1        (a1),
      .a2        (a2),
      .a3        (a3),
      .a4        (a4),
      .match     (match),
      .cnt       (cnt),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [3:0] m_a [4];
   int         m_cnt;
   int         cyc;
   int         ignore_until;
   int         clear_edge;
   bit         clear_digits;
   int         match_edge;
   int         err_edge;
   bit         exp_match;
   bit         exp_err;

   function automatic bit has_dup();
      bit d = 1'b0;
      for (int i = 0; i < 4; i++)
         for (int j = i + 1; j < 4; j++)
            if (m_a[i] == m_a[j]) d = 1'b1;
      return d;
   endfunction

   function automatic bit guess_accepted();
`ifdef GUESS_DUP_CHECK_EN
      return !has_dup();
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_a[i] = 4'd0;
      m_cnt        = 0;
      ignore_until = -100;
      clear_edge   = -100;
      clear_digits = 1'b0;
      match_edge   = -100;
      err_edge     = -100;
      exp_match    = 1'b0;
      exp_err      = 1'b0;
   endtask

   // Advances the model by one rising edge with the key seen on that edge.
   task automatic model_edge(input bit v, input logic [3:0] k);
      exp_match = (cyc == match_edge);
      exp_err   = (cyc == err_edge);
      if (cyc == clear_edge) begin
         m_cnt = 0;
         if (clear_digits)
            for (int i = 0; i < 4; i++) m_a[i] = 4'd0;
      end else if (v && cyc > ignore_until) begin
         if (k <= 4'd9) begin
            if (m_cnt < 4) begin
               m_a[m_cnt] = k;
               m_cnt++;
            end
         end else if (k == 4'hC) begin
            m_cnt = 0;
            for (int i = 0; i < 4; i++) m_a[i] = 4'd0;
         end else if (k == 4'hE && m_cnt == 4) begin
            if (guess_accepted()) begin
               ignore_until = cyc + 2;
               clear_edge   = cyc + 2;
               clear_digits = 1'b0;
               match_edge   = cyc + 2;
            end else begin
               ignore_until = cyc + 1;
               clear_edge   = cyc + 1;
               clear_digits = 1'b1;
               err_edge     = cyc + 2;
            end
         end
      end
   endtask

   function automatic logic [20:0] exp_vec();
      logic [2:0] c = 3'(m_cnt);
      return {c, m_a[0], m_a[1], m_a[2], m_a[3], exp_match, exp_err};
   endfunction

   function automatic logic [20:0] got_vec();
      return {cnt, a1, a2, a3, a4, match, err};
   endfunction

   // Drives one key (called at a falling edge), lets one rising edge pass,
   // and returns at the next falling edge where outputs are stable.
   task automatic step(input bit v, input logic [3:0] k);
      key_valid = v;
      key_code  = k;
      @(posedge clk);
      cyc++;
      model_edge(v, k);
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'd0;
   endtask

   // Asserts reset between edges and checks that state clears immediately.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      if (got_vec() !== exp_vec()) begin
         errors++;
         $display("[TB] FAIL async_reset got=%h exp=%h", got_vec(), exp_vec());
      end
      checks++;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      // Keys presented while reset is held must not be taken.
      key_valid = 1'b1;
      key_code  = 4'd7;
      @(posedge clk);
      @(negedge clk);
      model_reset();
      if (got_vec() !== exp_vec()) begin
         errors++;
         $display("[TB] FAIL reset_hold got=%h exp=%h", got_vec(), exp_vec());
      end
      checks++;
      key_valid = 1'b0;
      rst = 1'b0;
      // First key after release is honoured on the very next edge.
      step(1'b1, 4'd5);
      if (got_vec() !== exp_vec()) begin
         errors++;
         $display("[TB] FAIL first_key got=%h exp=%h", got_vec(), exp_vec());
      end
      checks++;
      do_reset();
   endtask

   task automatic test_directed();
      logic [63:0] words [5];
      int          lens  [5];
      logic [3:0]  k;
      words[0] = 64'h1234E;    lens[0] = 5;
      words[1] = 64'h5567E;    lens[1] = 5;
      words[2] = 64'h12E349E;  lens[2] = 7;
      words[3] = 64'h87C0123E; lens[3] = 8;
      words[4] = 64'h1234E9B6; lens[4] = 8;
      for (int s = 0; s < 5; s++) begin
         for (int i = 0; i < lens[s] + 4; i++) begin
            if (i < lens[s]) begin
               k = words[s][4*(lens[s]-1-i) +: 4];
               step(1'b1, k);
            end else begin
               step(1'b0, 4'd0);
            end
            if (got_vec() !== exp_vec()) begin
               errors++;
               $display("[TB] FAIL directed seq=%0d step=%0d got=%h exp=%h",
                        s, i, got_vec(), exp_vec());
            end
            checks++;
         end
         do_reset();
      end
   endtask

   task automatic test_reset_abort();
      logic [3:0] keys1 [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'hE};
      logic [3:0] keys2 [5] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'hE};
      int         points [3] = '{3, 5, 6};
      for (int p = 0; p < 3; p++) begin
         // Abort mid-entry, in CHECK, and in DONE respectively.
         for (int i = 0; i < points[p]; i++)
            step(i < 5, (i < 5) ? keys1[i] : 4'd0);
         do_reset();
         for (int i = 0; i < 12; i++) begin
            if (i >= 2 && i < 7) step(1'b1, keys2[i-2]);
            else                 step(1'b0, 4'd0);
            if (got_vec() !== exp_vec()) begin
               errors++;
               $display("[TB] FAIL reset_abort point=%0d step=%0d got=%h exp=%h",
                        p, i, got_vec(), exp_vec());
            end
            checks++;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] keys [14] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'hE, 4'd0, 4'd0,
                                4'd9, 4'd8, 4'd7, 4'd6, 4'hE, 4'd2, 4'd3};
      for (int i = 0; i < 20; i++) begin
         if (i < 14) step(1'b1, keys[i]);
         else        step(1'b0, 4'd0);
         if (got_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL back_to_back step=%0d got=%h exp=%h",
                     i, got_vec(), exp_vec());
         end
         checks++;
      end
   endtask

   task automatic test_random();
      logic [3:0] k;
      bit         v;
      int         r;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 149) == 0) do_reset();
         v = ($urandom_range(0, 9) < 7);
         r = $urandom_range(0, 99);
         if (r < 20)      k = 4'hE;
         else if (r < 25) k = 4'hC;
         else if (r < 32) k = 4'(10 + $urandom_range(0, 5));
         else             k = 4'($urandom_range(0, 9));
         step(v, k);
         if (got_vec() !== exp_vec() || (match && err)) begin
            errors++;
            $display("[TB] FAIL random step=%0d got=%h exp=%h",
                     i, got_vec(), exp_vec());
         end
         checks++;
      end
   endtask

   initial begin
      rst       = 1'b1;
      key_valid = 1'b0;
      key_code  = 4'd0;
      cyc       = 0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_directed();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/guess_entry.md
GUESS_ENTRY -- requirements
Module: guess_entry

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high; clears all state immediately.
REQ-003 key_valid  input  1  one-cycle strobe; key_code sampled only when high.
REQ-004 key_code  input  4  0-9 digit; 4'hC clear; 4'hE enter; 4'hA/B/D/F ignored.
REQ-005 a1,a2,a3,a4  output  4 each  registered guess digits, a1 = first entered; drive the matcher's a-inputs.
REQ-006 match  output  1  registered one-cycle pulse; guess complete and valid; drives the matcher's match input.
REQ-007 cnt  output  3  number of digits held, 0-4.
REQ-008 err  output  1  registered one-cycle pulse; guess rejected at enter.

Function
REQ-009 FSM states SHALL be ENTRY, CHECK, DONE, encoded in 2 bits; unused code SHALL go to ENTRY.
REQ-010 In ENTRY, a digit with cnt<4 SHALL be written to a[cnt+1] and cnt SHALL increment on the same edge.
REQ-011 In ENTRY, a digit with cnt==4 SHALL be ignored; no register changes.
REQ-012 In ENTRY, clear SHALL set cnt=0 and a1..a4=0 on that edge.
REQ-013 In ENTRY, enter with cnt==4 SHALL move to CHECK; enter with cnt<4 SHALL be ignored.
REQ-014 CHECK SHALL last exactly one cycle. Valid guess: go to DONE and set match=1 for the following cycle. Invalid guess: go to ENTRY, set err=1 for one cycle, set cnt=0, and clear a1..a4.
REQ-015 DONE SHALL last exactly one cycle, then return to ENTRY with match=0 and cnt=0; a1..a4 SHALL hold until the next digit overwrites a1.
REQ-016 Latency: enter sampled at edge N -> match (or err) high between edges N+2 and N+3.
REQ-017 key_valid during CHECK or DONE SHALL be ignored, including clear.
REQ-018 match and err SHALL never be high in the same cycle; neither SHALL be high for more than one consecutive cycle.
REQ-019 Digit codes >9 other than C/E SHALL never be stored in a1..a4.

Reset
REQ-020 While rst is high: state=ENTRY, cnt=0, a1..a4=0, match=0, err=0.
REQ-021 rst asserted mid-entry, in CHECK, or in DONE SHALL abort with no match or err pulse.
REQ-022 The first key_valid SHALL be honoured on the first rising edge after rst deasserts.

Configuration
REQ-023 Macro GUESS_DUP_CHECK_EN defined: CHECK SHALL flag invalid if any pair of a1..a4 is equal (6 comparisons).
REQ-024 Macro GUESS_DUP_CHECK_EN undefined: CHECK SHALL always pass; err SHALL be tied 0.

Verification
REQ-025 Keys 1,2,3,4,E -> a1..a4=1,2,3,4; cnt 1..4; match=1 exactly one cycle, 2 edges after E; cnt=0 after.
REQ-026 Keys 5,5,6,7,E with GUESS_DUP_CHECK_EN -> err=1 one cycle, match never high, cnt=0, a1..a4=0. Without the macro -> match=1, a1..a4=5,5,6,7.
REQ-027 Keys 1,2,E,3,4,9,E -> first E ignored; 9 ignored at cnt==4; match with a1..a4=1,2,3,4.
REQ-028 Keys 8,7,C,0,1,2,3,E -> cnt=0 after C; match with a1..a4=0,1,2,3.
REQ-029 Keys 1,2,3 then rst pulse, then 4,5,6,7,E -> cnt=0 during reset; a1..a4=4,5,6,7; single match pulse.
REQ-030 Key 9 on the cycle after E (during CHECK) -> ignored; match pulse; next digit entered lands in a1.
